vote_tally: RTL and testbench

VOTE_TALLY -- requirements
Module: vote_tally

---
 rtl/vote_pkg.sv | 14 +
 rtl/vote_counter.sv | 25 ++
 rtl/vote_tally.sv | 125 ++++++++++++
 tb/tb_vote_tally.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the vote tally block: poll-state encoding and
// default sizing constants.
package vote_pkg;

  typedef enum logic [1:0] {
    POLL_IDLE   = 2'd0,
    POLL_OPEN   = 2'd1,
    POLL_CLOSED = 2'd2
  } poll_state_e;

  localparam int NUM_CAND_DEF = 4;
  localparam int COUNT_W_DEF  = 8;

endpackage

// File: rtl/vote_counter.sv
// Per-candidate saturating tally counter; at_max blocks further increments
// so a full count never wraps.
module vote_counter
  import vote_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [COUNT_W-1:0] count,
  output logic               at_max
);

  assign at_max = &count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/vote_tally.sv
// Poll controller: accepts one-hot votes while the poll is open, keeps per
// candidate and total tallies, tracks the leader and gates readback.
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int SEL_W    = $clog2(NUM_CAND),
  parameter int TOTAL_W  = COUNT_W + SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               open_poll,
  input  logic               close_poll,
  input  logic [NUM_CAND-1:0] vote_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [COUNT_W-1:0] rd_count,
  output logic [TOTAL_W-1:0] total_votes,
  output logic               vote_ack,
  output logic               vote_rej,
  output logic [SEL_W-1:0]   leader,
  output logic               leader_tie,
  output logic [1:0]         poll_state
);

  poll_state_e state, state_nxt;

  logic [COUNT_W-1:0]  cnt [NUM_CAND];
  logic [NUM_CAND-1:0] at_max_vec;
  logic [NUM_CAND-1:0] inc_vec;
  logic                vote_any;
  logic                vote_onehot;
  logic                tgt_max;
  logic                accept;
  logic                secret;
  logic [SEL_W-1:0]    tgt;
  logic [COUNT_W-1:0]  tgt_cnt;
  logic [COUNT_W-1:0]  tgt_cnt_new;
  logic [COUNT_W-1:0]  lead_cnt;
  logic [COUNT_W-1:0]  rd_mux;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cnt
    vote_counter #(
      .COUNT_W(COUNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc_vec[g]),
      .count  (cnt[g]),
      .at_max (at_max_vec[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= POLL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      POLL_IDLE:   if (open_poll)  state_nxt = POLL_OPEN;
      POLL_OPEN:   if (close_poll) state_nxt = POLL_CLOSED;
      POLL_CLOSED: state_nxt = POLL_CLOSED;
      default:     state_nxt = POLL_IDLE;
    endcase
  end

  // Index-driven muxes: vote target, current leader's count and readback.
  always_comb begin
    tgt      = '0;
    tgt_cnt  = '0;
    lead_cnt = '0;
    rd_mux   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_req[i]) begin
        tgt     = SEL_W'(i);
        tgt_cnt = cnt[i];
      end
      if (leader == SEL_W'(i)) lead_cnt = cnt[i];
      if (rd_sel == SEL_W'(i)) rd_mux = cnt[i];
    end
  end

  assign vote_any    = |vote_req;
  assign vote_onehot = vote_any && ((vote_req & (vote_req - NUM_CAND'(1))) == '0);
  assign tgt_max     = |(vote_req & at_max_vec);
  // State is sampled before the edge: a vote alongside open_poll sees IDLE,
  // a vote alongside close_poll still sees OPEN.
  assign accept      = (state == POLL_OPEN) && !mode && vote_onehot && !tgt_max;
  assign inc_vec     = accept ? vote_req : '0;
  assign tgt_cnt_new = tgt_cnt + COUNT_W'(1);
  assign secret      = (state == POLL_OPEN) && !mode;
  assign poll_state  = state;

  // Registered outputs, one cycle behind the sampled request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_votes <= '0;
      vote_ack    <= 1'b0;
      vote_rej    <= 1'b0;
      leader      <= '0;
      leader_tie  <= 1'b1;
      rd_count    <= '0;
    end else begin
      vote_ack <= accept;
      vote_rej <= vote_any && !accept;
      rd_count <= secret ? '0 : rd_mux;
      if (accept) begin
        total_votes <= total_votes + TOTAL_W'(1);
        if (tgt_cnt_new > lead_cnt) begin
          leader     <= tgt;
          leader_tie <= 1'b0;
        end else if ((tgt_cnt_new == lead_cnt) && (tgt != leader)) begin
          leader_tie <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: directed table, saturation and reset sequences, then
// randomized traffic against a rule-level reference model.
module tb_vote_tally;

  localparam int NC = 3;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mode = 1'b0;
  logic          open_poll = 1'b0;
  logic          close_poll = 1'b0;
  logic [NC-1:0] vote_req = '0;
  logic [SW-1:0] rd_sel = '0;
  logic [CW-1:0] rd_count;
  logic [TW-1:0] total_votes;
  logic          vote_ack;
  logic          vote_rej;
  logic [SW-1:0] leader;
  logic          leader_tie;
  logic [1:0]    poll_state;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_total, m_lead, m_rd;
  int m_cnt [NC];
  bit m_ack, m_rej, m_tie;

  typedef struct {
    bit         md, op, cl;
    logic [2:0] req;
    logic [1:0] sel;
    bit         ack, rej;
    int         total, lead;
    bit         tie;
    int         st, rd;
  } row_t;

  row_t tbl [13];

  vote_tally #(
    .NUM_CAND (NC),
    .COUNT_W  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .open_poll   (open_poll),
    .close_poll  (close_poll),
    .vote_req    (vote_req),
    .rd_sel      (rd_sel),
    .rd_count    (rd_count),
    .total_votes (total_votes),
    .vote_ack    (vote_ack),
    .vote_rej    (vote_rej),
    .leader      (leader),
    .leader_tie  (leader_tie),
    .poll_state  (poll_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_total = 0; m_lead = 0; m_rd = 0;
    m_ack = 0; m_rej = 0; m_tie = 1;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input bit md, input bit op, input bit cl,
                            input logic [NC-1:0] rq, input logic [SW-1:0] sl);
    int idx, ones, n;
    bit acc;
    idx  = 0;
    ones = $countones(rq);
    for (int i = 0; i < NC; i++) if (rq[i]) idx = i;
    acc = (m_st == 1) && !md && (ones == 1) && (m_cnt[idx] < (1 << CW) - 1);
    if (m_st == 1 && !md) m_rd = 0;
    else m_rd = (int'(sl) < NC) ? m_cnt[int'(sl)] : 0;
    m_ack = acc;
    m_rej = (rq != 0) && !acc;
    if (acc) begin
      n = m_cnt[idx] + 1;
      if (n > m_cnt[m_lead]) begin
        m_lead = idx;
        m_tie  = 0;
      end else if (n == m_cnt[m_lead] && idx != m_lead) begin
        m_tie = 1;
      end
      m_cnt[idx] = n;
      m_total++;
    end
    if (m_st == 0 && op) m_st = 1;
    else if (m_st == 1 && cl) m_st = 2;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ack"},   vote_ack,    m_ack);
    check({tag, ".rej"},   vote_rej,    m_rej);
    check({tag, ".total"}, total_votes, m_total);
    check({tag, ".lead"},  leader,      m_lead);
    check({tag, ".tie"},   leader_tie,  m_tie);
    check({tag, ".state"}, poll_state,  m_st);
    check({tag, ".rd"},    rd_count,    m_rd);
  endtask

  task automatic cycle(input bit md, input bit op, input bit cl,
                       input logic [NC-1:0] rq, input logic [SW-1:0] sl, input string tag);
    mode = md; open_poll = op; close_poll = cl; vote_req = rq; rd_sel = sl;
    model_step(md, op, cl, rq, sl);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mode = 0; open_poll = 0; close_poll = 0; vote_req = '0; rd_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_all("reset");
  endtask

  initial begin
    bit md, op, cl;
    logic [NC-1:0] rq;
    int r;

    tbl[0]  = '{0, 1, 0, 3'b001, 2'd0, 0, 1, 0, 0, 1, 1, 0};
    tbl[1]  = '{0, 0, 0, 3'b001, 2'd0, 1, 0, 1, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 3'b010, 2'd0, 1, 0, 2, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 3'b010, 2'd0, 1, 0, 3, 1, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 3'b011, 2'd0, 0, 1, 3, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 0, 3'b001, 2'd0, 1, 0, 4, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 1, 3'b100, 2'd0, 1, 0, 5, 1, 1, 2, 0};
    tbl[7]  = '{0, 0, 0, 3'b100, 2'd0, 0, 1, 5, 1, 1, 2, 2};
    tbl[8]  = '{1, 0, 0, 3'b000, 2'd0, 0, 0, 5, 1, 1, 2, 2};
    tbl[9]  = '{1, 0, 0, 3'b000, 2'd1, 0, 0, 5, 1, 1, 2, 2};
    tbl[10] = '{1, 0, 0, 3'b000, 2'd2, 0, 0, 5, 1, 1, 2, 1};
    tbl[11] = '{1, 0, 0, 3'b000, 2'd3, 0, 0, 5, 1, 1, 2, 0};
    tbl[12] = '{1, 1, 0, 3'b000, 2'd2, 0, 0, 5, 1, 1, 2, 1};

    // Directed table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      mode = tbl[i].md; open_poll = tbl[i].op; close_poll = tbl[i].cl;
      vote_req = tbl[i].req; rd_sel = tbl[i].sel;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.ack", i),   vote_ack,    tbl[i].ack);
      check($sformatf("tbl%0d.rej", i),   vote_rej,    tbl[i].rej);
      check($sformatf("tbl%0d.total", i), total_votes, tbl[i].total);
      check($sformatf("tbl%0d.lead", i),  leader,      tbl[i].lead);
      check($sformatf("tbl%0d.tie", i),   leader_tie,  tbl[i].tie);
      check($sformatf("tbl%0d.state", i), poll_state,  tbl[i].st);
      check($sformatf("tbl%0d.rd", i),    rd_count,    tbl[i].rd);
    end

    // Saturation of a 4-bit counter.
    do_reset();
    cycle(0, 1, 0, 3'b000, 2'd0, "sat_open");
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 3'b100, 2'd0, "sat_vote");
    check("sat_last_rej", vote_rej, 1);
    check("sat_last_ack", vote_ack, 0);
    check("sat_total", total_votes, 15);
    cycle(1, 0, 0, 3'b000, 2'd2, "sat_read");
    check("sat_rd", rd_count, 15);

    // Asynchronous reset mid-poll.
    do_reset();
    cycle(0, 1, 0, 3'b000, 2'd0, "arst_open");
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, (i % 2) ? 3'b010 : 3'b001, 2'd0, "arst_vote");
    cycle(1, 0, 0, 3'b001, 2'd0, "arst_mode1");
    #3;
    reset = 1'b0;
    #1;
    check("arst.state", poll_state, 0);
    check("arst.total", total_votes, 0);
    check("arst.ack", vote_ack, 0);
    check("arst.rej", vote_rej, 0);
    check("arst.rd", rd_count, 0);
    check("arst.lead", leader, 0);
    check("arst.tie", leader_tie, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1, 0, 0, 3'b000, 2'd0, "arst_after");
    cycle(1, 0, 0, 3'b000, 2'd1, "arst_after");

    // Randomized traffic.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        op = ($urandom % 12) == 0;
        cl = ($urandom % 70) == 0;
        md = ($urandom % 8) == 0;
        r  = $urandom % 4;
        if (r == 0) rq = '0;
        else if (r < 3) rq = NC'(1 << ($urandom % NC));
        else rq = NC'($urandom % 8);
        cycle(md, op, cl, rq, SW'($urandom % 4), "rand");
      end
    end

    mode = 0; open_poll = 0; close_poll = 0; vote_req = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
